regfile_access_ctrl: RTL and testbench
======================================

// Module: regfile_access_ctrl
// PURPOSE
//   Initiator side of the register-file port (cs/rd/wr, two read addresses, one write address, 16-bit data).
//   Accepts one operation request: src1, src2, dst, wb_en.
//   Reads both source registers, hands the operands to the execute unit over a valid/ready handshake,
//   waits for the result and optionally writes it back.
//   Sits between the instruction decoder and the RegisterFile/ALU pair in the CPU datapath.
// PARAMETERS
//   DATA_W   16   register/operand width
//   ADDR_W   3    register address width (8 registers)
//   TIMEOUT  15   max cycles in WAIT_RES before abort; counter width = $clog2(TIMEOUT+1)
// PORTS
//   clk           in   1       single clock, rising edge
//   rst           in   1       synchronous, active-high reset
//   req_valid     in   1       operation request valid
//   req_ready     out  1       controller idle, can accept request
//   req_src1      in   ADDR_W  first source register
//   req_src2      in   ADDR_W  second source register
//   req_dst       in   ADDR_W  destination register
//   req_wb_en     in   1       1 = write result back to req_dst
//   rf_cs         out  1       register-file chip select
//   rf_rd         out  1       register-file read strobe
//   rf_wr         out  1       register-file write strobe
//   rf_rd_reg1    out  ADDR_W  read address 1
//   rf_rd_reg2    out  ADDR_W  read address 2
//   rf_rd_data1   in   DATA_W  read data 1, combinational, valid in the cycle rf_rd=1
//   rf_rd_data2   in   DATA_W  read data 2
//   rf_wr_reg     out  ADDR_W  write address
//   rf_wr_data    out  DATA_W  write data
//   op_valid      out  1       operands valid toward execute unit
//   op_ready      in   1       execute unit accepts operands
//   op_a, op_b    out  DATA_W  registered operands
//   res_valid     in   1       result valid (1-cycle pulse or held; first sample taken)
//   res_data      in   DATA_W  result value
//   done          out  1       1-cycle pulse: operation complete
//   timeout_err   out  1       1-cycle pulse together with done when result never arrived
// BEHAVIOUR
//   - Reset: state=IDLE; all outputs 0 except req_ready=1; operand, result and address registers cleared.
//   - FSM:
//       IDLE     -> READ when req_valid & req_ready; latch src1/src2/dst/wb_en.
//       READ     (1 cycle) rf_cs=rf_rd=1, rf_rd_reg1/2 = latched srcs; capture rf_rd_data1/2 into op_a/op_b -> ISSUE.
//       ISSUE    op_valid=1 with stable op_a/op_b until op_valid&op_ready; then -> WAIT_RES, clear timeout counter.
//       WAIT_RES res_valid -> latch res_data; -> WRITE if wb_en, else -> DONE.
//                Counter reaches TIMEOUT without res_valid -> DONE with timeout_err=1, no write.
//       WRITE    (1 cycle) rf_cs=rf_wr=1, rf_wr_reg=dst, rf_wr_data=result -> DONE.
//       DONE     (1 cycle) done=1 -> IDLE.
//   - rf_rd and rf_wr are never asserted in the same cycle; rf_cs=0 outside READ/WRITE.
//   - req_ready=1 only in IDLE; a request held during busy states is ignored until IDLE.
//   - Minimum latency, accept to done: with op_ready=1 in ISSUE and res_valid in the first WAIT_RES cycle,
//     5 cycles with wb_en=1 and 4 with wb_en=0.
//   - res_valid during ISSUE is ignored. op_ready outside ISSUE is ignored.
//   - src1==src2 is legal: identical operands. dst equal to a source is legal: the write happens after the read.
//   - rst asserted mid-operation: return to IDLE next edge; no write issued; no done pulse.
//   - Timeout counter saturates; no wrap.
// STRUCTURE
//   - Shared package rf_ctrl_pkg:
//       state enum encoding (IDLE, READ, ISSUE, WAIT_RES, WRITE, DONE);
//       DATA_W/ADDR_W defaults, shared with RegisterFile.
//   - Single module; no sub-module needed. Timeout counter is inline.
// TESTING
//   1. Reset: hold rst 2 cycles -> req_ready=1; rf_cs/rf_rd/rf_wr/op_valid/done=0.
//   2. Basic op: R1=0x0003, R2=0x0004, src1=1 src2=2 dst=3 wb_en=1, ALU returns 0x0007 immediately
//      -> READ shows rd_reg1=1 rd_reg2=2; op_a=3 op_b=4; write reg3=0x0007; done 5 cycles after accept.
//   3. Backpressure: op_ready low 3 cycles -> op_valid held, op_a/op_b stable; res_valid during ISSUE ignored.
//   4. wb_en=0 -> rf_wr never asserted; done 4 cycles after accept.
//   5. No res_valid -> timeout_err=1 with done exactly TIMEOUT cycles after ISSUE handshake; no write.
//   6. rst asserted in WAIT_RES -> IDLE next cycle, no rf_wr, no done; a new request then completes normally.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file access controller and the RegisterFile it drives.
package rf_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_WRITE    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: reads two sources, hands operands to the execute unit,
// waits (bounded) for the result and optionally writes it back.
module regfile_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W  = rf_ctrl_pkg::DATA_W,
  parameter int ADDR_W  = rf_ctrl_pkg::ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_src1,
  input  logic [ADDR_W-1:0] req_src2,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic              req_wb_en,
  output logic              rf_cs,
  output logic              rf_rd,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_rd_reg1,
  output logic [ADDR_W-1:0] rf_rd_reg2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output logic [ADDR_W-1:0] rf_wr_reg,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              done,
  output logic              timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  state_t          state;
  logic            wb_en;
  logic [CW-1:0]   to_cnt;
  logic [CW-1:0]   to_cnt_nxt;

  // Saturating increment: the counter can never wrap back past the limit.
  assign to_cnt_nxt = (to_cnt == TO_LIM) ? to_cnt : to_cnt + 1'b1;

  // Single FSM; every output is registered and set on entry to the state that owns it.
  // The latched request lives directly in the address outputs, and rf_wr_data doubles
  // as the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      rf_cs       <= 1'b0;
      rf_rd       <= 1'b0;
      rf_wr       <= 1'b0;
      rf_rd_reg1  <= '0;
      rf_rd_reg2  <= '0;
      rf_wr_reg   <= '0;
      rf_wr_data  <= '0;
      op_valid    <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      wb_en       <= 1'b0;
      to_cnt      <= '0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          // req_ready is 1 throughout IDLE, so req_valid alone is the handshake
          if (req_valid) begin
            rf_rd_reg1 <= req_src1;
            rf_rd_reg2 <= req_src2;
            rf_wr_reg  <= req_dst;
            wb_en      <= req_wb_en;
            req_ready  <= 1'b0;
            rf_cs      <= 1'b1;
            rf_rd      <= 1'b1;
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          op_a     <= rf_rd_data1;
          op_b     <= rf_rd_data2;
          rf_cs    <= 1'b0;
          rf_rd    <= 1'b0;
          op_valid <= 1'b1;
          state    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            to_cnt   <= '0;
            state    <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (res_valid) begin
            rf_wr_data <= res_data;
            if (wb_en) begin
              rf_cs <= 1'b1;
              rf_wr <= 1'b1;
              state <= ST_WRITE;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end else begin
            to_cnt <= to_cnt_nxt;
            // Abort once TIMEOUT cycles have been spent waiting
            if (to_cnt_nxt == TO_LIM) begin
              done        <= 1'b1;
              timeout_err <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          rf_cs <= 1'b0;
          rf_wr <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          rf_cs     <= 1'b0;
          rf_rd     <= 1'b0;
          rf_wr     <= 1'b0;
          op_valid  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: the bench plays register file and execute unit,
// runs a directed table, a reset-abort sequence and random operations against a
// transaction-level model (register array + latency arithmetic).
module tb_regfile_access_ctrl;
  import rf_ctrl_pkg::*;

  localparam int T = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_src1 = '0, req_src2 = '0, req_dst = '0;
  logic              req_wb_en = 1'b0;
  logic              rf_cs, rf_rd, rf_wr;
  logic [ADDR_W-1:0] rf_rd_reg1, rf_rd_reg2, rf_wr_reg;
  logic [DATA_W-1:0] rf_rd_data1, rf_rd_data2, rf_wr_data;
  logic              op_valid;
  logic              op_ready = 1'b0;
  logic [DATA_W-1:0] op_a, op_b;
  logic              res_valid = 1'b0;
  logic [DATA_W-1:0] res_data = '0;
  logic              done, timeout_err;

  always #5 clk = ~clk;

  regfile_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst), .req_wb_en(req_wb_en),
    .rf_cs(rf_cs), .rf_rd(rf_rd), .rf_wr(rf_wr),
    .rf_rd_reg1(rf_rd_reg1), .rf_rd_reg2(rf_rd_reg2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_data(res_data),
    .done(done), .timeout_err(timeout_err)
  );

  // Register file seen by the DUT, and the expected contents.
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] mdl  [8];
  assign rf_rd_data1 = rf_rd ? regs[rf_rd_reg1] : 16'hdead;
  assign rf_rd_data2 = rf_rd ? regs[rf_rd_reg2] : 16'hbeef;

  int n_chk = 0, n_pass = 0, wr_cnt = 0;

  typedef struct {
    int s1, s2, d, wb, rdy, rdl, nores;
    logic [DATA_W-1:0] res;
    int lat, to;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Advance one cycle and sample 1 time unit after the edge; a write strobe seen in
  // this cycle lands in the register file (reads never coincide with it).
  task automatic step();
    @(posedge clk);
    #1;
    if (rf_cs && rf_wr) begin
      regs[rf_wr_reg] = rf_wr_data;
      wr_cnt++;
    end
  endtask

  task automatic run_op(input vec_t v, input bit busy_junk);
    int c, iss, widx, wr0;
    bit hs, seen;
    chk("idle_ready", {31'd0, req_ready}, 1);
    req_valid = 1'b1;
    req_src1 = 3'(v.s1); req_src2 = 3'(v.s2); req_dst = 3'(v.d); req_wb_en = v.wb[0];
    wr0 = wr_cnt; c = 0; iss = 0; widx = 0; hs = 0; seen = 0;
    while (!seen && c < 60) begin
      step();
      c++;
      // requests presented while busy must be ignored
      req_valid = busy_junk;
      req_src1 = 3'($urandom); req_src2 = 3'($urandom); req_dst = 3'($urandom);
      req_wb_en = 1'($urandom);
      chk("busy_ready", {31'd0, req_ready}, 0);
      if (c == 1) begin
        chk("rd_strobes", {29'd0, rf_cs, rf_rd, rf_wr}, 3'b110);
        chk("rd_reg1", rf_rd_reg1, v.s1);
        chk("rd_reg2", rf_rd_reg2, v.s2);
      end else if (rf_rd) begin
        chk("stray_rd", {31'd0, rf_rd}, 0);
      end
      if (rf_wr) begin
        chk("wr_reg", rf_wr_reg, v.d);
        chk("wr_data", rf_wr_data, v.res);
        chk("wr_strobes", {30'd0, rf_cs, rf_rd}, 2'b10);
      end
      if (op_valid) begin
        chk("op_a", op_a, mdl[v.s1]);
        chk("op_b", op_b, mdl[v.s2]);
      end
      if (done) begin
        seen = 1;
        chk("latency", c, v.lat);
        chk("timeout_err", {31'd0, timeout_err}, v.to);
        req_valid = 1'b0;
      end
      // execute unit
      op_ready  = 1'($urandom);
      res_valid = 1'b0;
      res_data  = 16'($urandom);
      if (op_valid) begin
        op_ready  = (iss >= v.rdy);
        iss++;
        res_valid = 1'($urandom);
      end else if (hs) begin
        if (v.nores == 0 && widx == v.rdl) begin
          res_valid = 1'b1;
          res_data  = v.res;
        end else if (v.nores == 0 && widx > v.rdl) begin
          res_valid = 1'($urandom);
        end
        widx++;
      end
      if (op_valid && op_ready) hs = 1;
    end
    if (!seen) chk("done_seen", 0, 1);
    if (v.wb != 0 && v.nores == 0) mdl[v.d] = v.res;
    chk("wr_count", wr_cnt - wr0, (v.wb != 0 && v.nores == 0) ? 1 : 0);
    for (int r = 0; r < 8; r++) chk("regfile", regs[r], mdl[r]);
    step();
  endtask

  initial begin
    vec_t v;
    int wr0;
    for (int r = 0; r < 8; r++) regs[r] = 16'($urandom);
    regs[1] = 16'h0003;
    regs[2] = 16'h0004;
    for (int r = 0; r < 8; r++) mdl[r] = regs[r];

    //          s1 s2 d wb rdy rdl nores res      lat      to
    vecs[0] = '{1, 2, 3, 1, 0, 0, 0, 16'h0007, 5,       0};
    vecs[1] = '{1, 2, 4, 1, 3, 0, 0, 16'h1234, 8,       0};
    vecs[2] = '{5, 6, 7, 0, 0, 0, 0, 16'h5555, 4,       0};
    vecs[3] = '{2, 3, 4, 1, 0, 0, 1, 16'h0bad, 3 + T,   1};
    vecs[4] = '{3, 3, 3, 1, 1, 2, 0, 16'h0a0a, 8,       0};
    vecs[5] = '{7, 0, 7, 0, 2, 1, 0, 16'hffff, 7,       0};

    // reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_strobes", {28'd0, rf_cs, rf_rd, rf_wr, op_valid}, 0);
    chk("rst_done", {30'd0, done, timeout_err}, 0);
    chk("rst_op_a", op_a, 0);

    for (int i = 0; i < 6; i++) run_op(vecs[i], i[0]);

    // reset while waiting for the result: nothing written, no done
    wr0 = wr_cnt;
    req_valid = 1'b1; req_src1 = 3'd4; req_src2 = 3'd5; req_dst = 3'd6; req_wb_en = 1'b1;
    step();
    req_valid = 1'b0; op_ready = 1'b1;
    step();
    chk("rstw_issue", {31'd0, op_valid}, 1);
    step();
    chk("rstw_wait", {31'd0, op_valid}, 0);
    rst = 1'b1; res_valid = 1'b1; res_data = 16'hbeef;
    step();
    rst = 1'b0; res_valid = 1'b0; op_ready = 1'b0;
    chk("rstw_ready", {31'd0, req_ready}, 1);
    chk("rstw_strobes", {28'd0, rf_cs, rf_wr, op_valid, done}, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rstw_quiet", {30'd0, rf_wr, done}, 0);
    end
    chk("rstw_nowrite", wr_cnt - wr0, 0);
    v = '{4, 5, 6, 1, 0, 0, 0, 16'h4242, 5, 0};
    run_op(v, 1'b0);

    // random operations
    for (int i = 0; i < 40; i++) begin
      v.s1 = $urandom_range(0, 7); v.s2 = $urandom_range(0, 7); v.d = $urandom_range(0, 7);
      v.wb = $urandom_range(0, 1); v.rdy = $urandom_range(0, 3); v.rdl = $urandom_range(0, 4);
      v.nores = ($urandom_range(0, 7) == 0) ? 1 : 0;
      v.res = 16'($urandom);
      v.to  = v.nores;
      v.lat = (v.nores != 0) ? 3 + v.rdy + T : 4 + v.rdy + v.rdl + v.wb;
      run_op(v, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
